// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner: prescaled digit slots, anti-ghost
// dead time, leading-zero suppression, registered active-low outputs.
module display_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 10000,
    parameter int DEAD   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DEAD_LD = DW'(DEAD);

    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    logic [DW-1:0]              dead;
    logic [DIGITS-1:0][3:0]     sh_val;
    logic [DIGITS-1:0]          sh_dp;

    logic       tick;
    logic       lz_zero;
    logic       blank_cur;
    logic [3:0] nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb tick = (cnt == CNT_MAX);
    always_comb nib  = sh_val[idx];

    // Digit idx is a leading zero when it and every higher nibble are zero
    always_comb begin
        lz_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) >= idx && sh_val[j] != 4'h0) begin
                lz_zero = 1'b0;
            end
        end
    end

    always_comb blank_cur = blank_lz && (idx != '0) && lz_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            idx  <= '0;
            dead <= DEAD_LD;
        end else begin
            if (tick) begin
                cnt  <= '0;
                idx  <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
                dead <= DEAD_LD;
            end else begin
                cnt <= cnt + CW'(1);
                if (dead != '0) begin
                    dead <= dead - DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_val <= '0;
            sh_dp  <= '0;
        end else if (load) begin
            sh_val <= value;
            sh_dp  <= dp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= '1;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else if (dead != '0 || blank_cur) begin
            an   <= '1;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(DIGITS'(1) << idx);
            seg  <= hex7(nib);
            dp_n <= ~sh_dp[idx];
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a slot-arithmetic reference model
// predicts each edge's outputs; a monitor pops and compares.
module tb_display_scan;

    localparam int DG = 4;
    localparam int DV = 4;
    localparam int DD = 1;

    typedef struct {
        logic [DG-1:0] an;
        logic [6:0]    seg;
        logic          dp_n;
    } exp_t;

    logic            clk;
    logic            reset_n;
    logic [4*DG-1:0] value;
    logic [DG-1:0]   dp;
    logic            load;
    logic            blank_lz;
    logic [DG-1:0]   an;
    logic [6:0]      seg;
    logic            dp_n;

    int total;
    int bad;
    int k;
    logic [4*DG-1:0] m_val;
    logic [DG-1:0]   m_dp;
    exp_t q[$];
    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

    display_scan #(.DIGITS(DG), .DIV(DV), .DEAD(DD)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .value(value),
        .dp(dp),
        .load(load),
        .blank_lz(blank_lz),
        .an(an),
        .seg(seg),
        .dp_n(dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: edge k after release sits at position (k-1)%DV of slot
    // (k-1)/DV; the first DD positions of every slot are dark.
    always @(posedge clk) begin
        exp_t e;
        int p;
        int s;
        int i;
        logic [4*DG-1:0] hi;
        if (!reset_n) begin
            k = 0;
            m_val = '0;
            m_dp = '0;
            e.an = '1;
            e.seg = 7'h7F;
            e.dp_n = 1'b1;
            q.push_back(e);
        end else begin
            k++;
            p = (k - 1) % DV;
            s = (k - 1) / DV;
            i = s % DG;
            hi = m_val >> (4 * i);
            if (p < DD || (blank_lz && i > 0 && hi == 0)) begin
                e.an = '1;
                e.seg = 7'h7F;
                e.dp_n = 1'b1;
            end else begin
                e.an = ~(DG'(1) << i);
                e.seg = segtab[hi[3:0]];
                e.dp_n = ~m_dp[i];
            end
            q.push_back(e);
            if (load) begin
                m_val = value;
                m_dp = dp;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = q.pop_front();
                if (an !== e.an || seg !== e.seg || dp_n !== e.dp_n) begin
                    bad++;
                    $display("FAIL scan k=%0d got an=%b seg=%h dp_n=%b want an=%b seg=%h dp_n=%b",
                             k, an, seg, dp_n, e.an, e.seg, e.dp_n);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*DG-1:0] v, input logic [DG-1:0] d);
        @(negedge clk);
        value = v;
        dp = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        bit found;
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        value = '0;
        dp = '0;
        load = 1'b0;
        blank_lz = 1'b0;
        cycles(3);
        reset_n = 1'b1;
        cycles(20);

        do_load(16'h12AF, 4'b0100);
        cycles(20);

        blank_lz = 1'b1;
        do_load(16'h0050, 4'b1100);
        cycles(20);
        do_load(16'h0000, 4'b1111);
        cycles(20);

        blank_lz = 1'b0;
        do_load(16'h0003, 4'b0000);
        found = 0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if ((k + 1) % (DV * DG) == 0) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL tick_search no tick edge found");
        end
        value = 16'h0008;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cycles(8);

        @(negedge clk);
        load = 1'b1;
        value = 16'h1111;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        value = 16'h0C3D;
        dp = 4'b1001;
        @(negedge clk);
        load = 1'b0;
        cycles(20);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            load = ($urandom % 6) == 0;
            case ($urandom % 4)
                0: value = 16'($urandom);
                1: value = 16'($urandom) & 16'h00FF;
                2: value = 16'($urandom) & 16'h000F;
                default: value = 16'h0000;
            endcase
            dp = 4'($urandom);
            if ($urandom % 16 == 0) blank_lz = ~blank_lz;
        end
        load = 1'b0;

        do_load(16'hFFFF, 4'b1111);
        cycles(6);
        @(negedge clk);
        #2;
        load = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1) begin
            bad++;
            $display("FAIL async_reset got an=%b seg=%h dp_n=%b want an=1111 seg=7f dp_n=1",
                     an, seg, dp_n);
        end
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        blank_lz = 1'b0;
        cycles(24);

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
